// File: rtl/ldvio_vld_writer.sv
// ---------------------------------------------------------------------------
// ldvio_vld_writer
//
// Write-side controller for the load-violation valid RAM. Training events
// from the LSU/commit path are buffered in a small FIFO and written one per
// cycle through the RAM's single write port. Periodically (decay counter) or
// on request (flush_i), every RAM entry is swept to zero so that stale
// violation predictions decay. Queued events are written after a sweep and
// therefore survive it.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   decay_en_i    enables the automatic decay counter
//   flush_i       one-cycle pulse requesting an immediate full sweep
//   vio_valid_i   violation event valid
//   vio_addr_i    RAM index for the event
//   vio_data_i    value to write for the event
//   vio_ready_o   event accepted when valid & ready at a rising edge
//   addr0wr_o     registered RAM write address
//   data0wr_o     registered RAM write data
//   we0_o         registered RAM write enable
//   sweep_busy_o  high while a sweep is in progress
// ---------------------------------------------------------------------------
module ldvio_vld_writer #(
  parameter int DEPTH        = 16,
  parameter int INDEX        = 4,
  parameter int WIDTH        = 8,
  parameter int QDEPTH       = 4,
  parameter int QINDEX       = 2,
  parameter int DECAY_PERIOD = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             decay_en_i,
  input  logic             flush_i,
  input  logic             vio_valid_i,
  input  logic [INDEX-1:0] vio_addr_i,
  input  logic [WIDTH-1:0] vio_data_i,
  output logic             vio_ready_o,
  output logic [INDEX-1:0] addr0wr_o,
  output logic [WIDTH-1:0] data0wr_o,
  output logic             we0_o,
  output logic             sweep_busy_o
);

  localparam int DCW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  localparam logic [QINDEX:0]  CNT_FULL   = (QINDEX+1)'(QDEPTH);
  localparam logic [QINDEX:0]  CNT_ONE    = (QINDEX+1)'(1);
  localparam logic [INDEX-1:0] SWEEP_LAST = INDEX'(DEPTH - 1);
  localparam logic [DCW-1:0]   DECAY_LAST = DCW'(DECAY_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWEEP = 2'd2
  } state_t;

  typedef struct packed {
    logic [INDEX-1:0] addr;
    logic [WIDTH-1:0] data;
  } entry_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  entry_t            fifo_mem [QDEPTH];
  logic [QINDEX-1:0] wr_ptr_q, rd_ptr_q;
  logic [QINDEX:0]   count_q,  count_d;
  state_t            state_q,  state_d;
  logic [INDEX-1:0]  sweep_ptr_q, sweep_ptr_d;
  logic [DCW-1:0]    decay_cnt_q, decay_cnt_d;
  logic              sweep_pend_q, sweep_pend_d;

  logic              wr_en_d;
  logic [INDEX-1:0]  wr_addr_d;
  logic [WIDTH-1:0]  wr_data_d;

  logic              push, pop, sweep_done;
  logic              decay_tick, sweep_req;
  entry_t            head;

  // Ready is purely occupancy based: a same-cycle pop does not free a slot.
  assign vio_ready_o  = (count_q < CNT_FULL);
  assign push         = vio_valid_i && vio_ready_o;
  assign head         = fifo_mem[rd_ptr_q];
  assign sweep_busy_o = (state_q == SWEEP);

  // A request arriving during a sweep is absorbed by that sweep.
  assign decay_tick = decay_en_i && (decay_cnt_q == DECAY_LAST);
  assign sweep_req  = (decay_tick || flush_i) && (state_q != SWEEP);

  // -------------------------------------------------------------------------
  // Next-state / write-port logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned; otherwise synthesis would infer a latch.
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    sweep_done  = 1'b0;
    pop         = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = addr0wr_o;
    wr_data_d   = data0wr_o;

    unique case (state_q)
      IDLE: begin
        if (sweep_pend_q)        state_d = SWEEP;
        else if (count_q != '0)  state_d = DRAIN;
      end

      DRAIN: begin
        // A pending sweep preempts the pop; the head stays queued.
        if (sweep_pend_q) begin
          state_d = SWEEP;
        end else if (count_q != '0) begin
          pop       = 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = head.addr;
          wr_data_d = head.data;
          if (count_q == CNT_ONE && !push) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end

      SWEEP: begin
        wr_en_d   = 1'b1;
        wr_addr_d = sweep_ptr_q;
        wr_data_d = '0;
        if (sweep_ptr_q == SWEEP_LAST) begin
          sweep_ptr_d = '0;
          sweep_done  = 1'b1;
          state_d     = (count_q != '0) ? DRAIN : IDLE;
        end else begin
          sweep_ptr_d = sweep_ptr_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    decay_cnt_d = decay_cnt_q;
    if (decay_en_i) decay_cnt_d = decay_tick ? '0 : decay_cnt_q + 1'b1;
  end

  assign sweep_pend_d = sweep_done ? 1'b0 : (sweep_pend_q | sweep_req);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sweep_ptr_q  <= '0;
      decay_cnt_q  <= '0;
      sweep_pend_q <= 1'b0;
      we0_o        <= 1'b0;
      addr0wr_o    <= '0;
      data0wr_o    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      sweep_ptr_q  <= sweep_ptr_d;
      decay_cnt_q  <= decay_cnt_d;
      sweep_pend_q <= sweep_pend_d;
      we0_o        <= wr_en_d;
      addr0wr_o    <= wr_addr_d;
      data0wr_o    <= wr_data_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the FIFO storage has no reset; an entry is only read after it has
  // been written, and count/pointers (which are reset) guard every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{addr: vio_addr_i, data: vio_data_i};
  end

endmodule

// File: tb/tb_ldvio_vld_writer.sv
// ---------------------------------------------------------------------------
// Directed testbench for ldvio_vld_writer. A monitor logs every RAM write
// with the index of the clock edge that produced it and keeps a shadow copy
// of the RAM; each scenario task compares that log against hand-derived
// expectations.
// ---------------------------------------------------------------------------
module tb_ldvio_vld_writer;

  logic       clk;
  logic       reset;
  logic       decay_en_i;
  logic       flush_i;
  logic       vio_valid_i;
  logic [3:0] vio_addr_i;
  logic [7:0] vio_data_i;
  logic       vio_ready_o;
  logic [3:0] addr0wr_o;
  logic [7:0] data0wr_o;
  logic       we0_o;
  logic       sweep_busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  ldvio_vld_writer #(
    .DEPTH(16), .INDEX(4), .WIDTH(8), .QDEPTH(4), .QINDEX(2), .DECAY_PERIOD(1024)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .decay_en_i   (decay_en_i),
    .flush_i      (flush_i),
    .vio_valid_i  (vio_valid_i),
    .vio_addr_i   (vio_addr_i),
    .vio_data_i   (vio_data_i),
    .vio_ready_o  (vio_ready_o),
    .addr0wr_o    (addr0wr_o),
    .data0wr_o    (data0wr_o),
    .we0_o        (we0_o),
    .sweep_busy_o (sweep_busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write monitor: cyc is the index of the most recent rising edge.
  typedef struct {
    int         cyc;
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wlog [$];
  logic [7:0] ram  [16];
  int         cyc = 0;

  initial for (int i = 0; i < 16; i++) ram[i] = 8'hFF;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (we0_o === 1'b1) begin
      wlog.push_back('{cyc: cyc, a: addr0wr_o, d: data0wr_o});
      ram[addr0wr_o] = data0wr_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    decay_en_i  = 1'b0;
    flush_i     = 1'b0;
    vio_valid_i = 1'b0;
    vio_addr_i  = '0;
    vio_data_i  = '0;
    wait_neg(2);
    reset = 1'b1;
    wait_neg(1);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({we0_o, addr0wr_o, data0wr_o, sweep_busy_o} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: we=%b addr=%0d data=%h busy=%b, required all 0",
               we0_o, addr0wr_o, data0wr_o, sweep_busy_o);
    end
    n_cmp++;
    if (vio_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: ready=%b, required 1", vio_ready_o);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single_event();
    int e;
    int ready_bad;
    ready_bad = 0;
    wlog.delete();
    @(negedge clk);
    vio_valid_i = 1'b1;
    vio_addr_i  = 4'd5;
    vio_data_i  = 8'h80;
    if (vio_ready_o !== 1'b1) ready_bad++;
    e = cyc + 1;
    @(negedge clk);
    vio_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (vio_ready_o !== 1'b1) ready_bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (ready_bad != 0) begin
      n_bad++;
      $display("FAIL single_ready: ready low in %0d cycles, required 0", ready_bad);
    end
    n_cmp++;
    if (wlog.size() != 1) begin
      n_bad++;
      $display("FAIL single_count: %0d writes, required 1", wlog.size());
    end else if (wlog[0].cyc != e + 2 || wlog[0].a !== 4'd5 || wlog[0].d !== 8'h80) begin
      n_bad++;
      $display("FAIL single_write: edge=+%0d addr=%0d data=%h, required edge=+2 addr=5 data=80",
               wlog[0].cyc - e, wlog[0].a, wlog[0].d);
    end
  endtask

  // -------------------------------------------------------------------------
  // Flush stalls the port; six held events, only four fit.
  task automatic test_backpressure();
    int f;
    logic [3:0] ea;
    logic [7:0] ed;
    wlog.delete();
    @(negedge clk);
    flush_i = 1'b1;
    f = cyc + 1;
    @(negedge clk);
    flush_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vio_valid_i = 1'b1;
      vio_addr_i  = 4'(i + 1);
      vio_data_i  = 8'(8'h10 + i);
      n_cmp++;
      if (vio_ready_o !== (i < 4)) begin
        n_bad++;
        $display("FAIL bp_ready[%0d]: ready=%b, required %b", i, vio_ready_o, (i < 4));
      end
      @(negedge clk);
    end
    vio_valid_i = 1'b0;
    wait_neg(25);
    n_cmp++;
    if (wlog.size() != 20) begin
      n_bad++;
      $display("FAIL bp_count: %0d writes, required 20", wlog.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        ea = (k < 16) ? 4'(k) : 4'(k - 15);
        ed = (k < 16) ? 8'h00 : 8'(8'h10 + k - 16);
        n_cmp++;
        if (wlog[k].cyc != f + 2 + k || wlog[k].a !== ea || wlog[k].d !== ed) begin
          n_bad++;
          $display("FAIL bp_write[%0d]: edge=+%0d addr=%0d data=%h, required edge=+%0d addr=%0d data=%h",
                   k, wlog[k].cyc - f, wlog[k].a, wlog[k].d, 2 + k, ea, ed);
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_flush_sweep();
    int f;
    int busy_n;
    int busy_first;
    int bad;
    busy_n = 0;
    busy_first = -1;
    bad = 0;
    wlog.delete();
    @(negedge clk);
    flush_i = 1'b1;
    f = cyc + 1;
    @(negedge clk);
    flush_i = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (sweep_busy_o === 1'b1) begin
        busy_n++;
        if (busy_first < 0) busy_first = cyc - f;
      end
    end
    n_cmp++;
    if (busy_n != 16 || busy_first != 1) begin
      n_bad++;
      $display("FAIL sweep_busy: high %0d cycles from edge +%0d, required 16 from +1",
               busy_n, busy_first);
    end
    n_cmp++;
    if (wlog.size() != 16) begin
      n_bad++;
      $display("FAIL sweep_count: %0d writes, required 16", wlog.size());
    end else begin
      for (int k = 0; k < 16; k++)
        if (wlog[k].cyc != f + 2 + k || wlog[k].a !== 4'(k) || wlog[k].d !== 8'h00) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL sweep_order: %0d writes out of place, required 0", bad);
      end
    end
    n_cmp++;
    if (we0_o !== 1'b0 || sweep_busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL sweep_idle: we=%b busy=%b, required 0 0", we0_o, sweep_busy_o);
    end
  endtask

  // -------------------------------------------------------------------------
  // Flush lands in the cycle the queued event would have been popped.
  task automatic test_preempt();
    int e;
    int bad;
    bad = 0;
    wlog.delete();
    @(negedge clk);
    vio_valid_i = 1'b1;
    vio_addr_i  = 4'd3;
    vio_data_i  = 8'h01;
    e = cyc + 1;
    @(negedge clk);
    vio_valid_i = 1'b0;
    flush_i     = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    wait_neg(25);
    n_cmp++;
    if (wlog.size() != 17) begin
      n_bad++;
      $display("FAIL preempt_count: %0d writes, required 17", wlog.size());
    end else begin
      for (int k = 0; k < 16; k++)
        if (wlog[k].cyc != e + 3 + k || wlog[k].a !== 4'(k) || wlog[k].d !== 8'h00) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL preempt_sweep: %0d sweep writes out of place, required 0", bad);
      end
      n_cmp++;
      if (wlog[16].cyc != e + 19 || wlog[16].a !== 4'd3 || wlog[16].d !== 8'h01) begin
        n_bad++;
        $display("FAIL preempt_event: edge=+%0d addr=%0d data=%h, required edge=+19 addr=3 data=01",
                 wlog[16].cyc - e, wlog[16].a, wlog[16].d);
      end
    end
    n_cmp++;
    if (ram[3] !== 8'h01) begin
      n_bad++;
      $display("FAIL preempt_ram3: ram[3]=%h, required 01", ram[3]);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_sweep();
    int f;
    wlog.delete();
    @(negedge clk);
    flush_i = 1'b1;
    f = cyc + 1;
    @(negedge clk);
    flush_i     = 1'b0;
    vio_valid_i = 1'b1;
    vio_addr_i  = 4'd9;
    vio_data_i  = 8'h99;
    @(negedge clk);
    vio_addr_i  = 4'd10;
    vio_data_i  = 8'hAA;
    @(negedge clk);
    vio_valid_i = 1'b0;
    wait_neg(6);
    // sweep_ptr is 7 here; addresses 0..6 have been written.
    n_cmp++;
    if (wlog.size() != 7) begin
      n_bad++;
      $display("FAIL rst_pre_writes: %0d writes before reset, required 7", wlog.size());
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({we0_o, addr0wr_o, data0wr_o, sweep_busy_o} !== 14'd0 || vio_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_async: we=%b addr=%0d data=%h busy=%b ready=%b, required 0 0 00 0 1",
               we0_o, addr0wr_o, data0wr_o, sweep_busy_o, vio_ready_o);
    end
    wlog.delete();
    wait_neg(2);
    reset = 1'b1;
    wait_neg(25);
    n_cmp++;
    if (wlog.size() != 0 || vio_ready_o !== 1'b1 || sweep_busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_after: writes=%0d ready=%b busy=%b, required 0 1 0",
               wlog.size(), vio_ready_o, sweep_busy_o);
    end
  endtask

  // -------------------------------------------------------------------------
  // Edge count from enabling the counter to the first cycle of SWEEP.
  task automatic test_decay(input bit pause, input int expect_k);
    int c0;
    int k;
    do_reset();
    @(negedge clk);
    decay_en_i = 1'b1;
    c0 = cyc;
    k  = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      k = cyc - c0;
      if (pause && k == 500) decay_en_i = 1'b0;
      if (pause && k == 600) decay_en_i = 1'b1;
      if (sweep_busy_o === 1'b1) break;
    end
    decay_en_i = 1'b0;
    n_cmp++;
    if (sweep_busy_o !== 1'b1 || k != expect_k) begin
      n_bad++;
      $display("FAIL decay_start(pause=%0d): sweep at edge +%0d busy=%b, required +%0d busy=1",
               pause, k, sweep_busy_o, expect_k);
    end
    wait_neg(20);
  endtask

  // -------------------------------------------------------------------------
  initial begin
    reset       = 1'b0;
    decay_en_i  = 1'b0;
    flush_i     = 1'b0;
    vio_valid_i = 1'b0;
    vio_addr_i  = '0;
    vio_data_i  = '0;

    test_reset();
    test_single_event();
    test_backpressure();
    test_flush_sweep();
    test_preempt();
    test_reset_mid_sweep();
    test_decay(1'b0, 1025);
    test_decay(1'b1, 1125);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
